// File: rtl/pcihellocore_led_driver_pkg.sv
// Register map and CTRL bit layout for the pcihellocore LED driver.
package pcihellocore_led_driver_pkg;

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrDuty   = 2'd1;
    localparam logic [1:0] AddrPeriod = 2'd2;
    localparam logic [1:0] AddrMask   = 2'd3;

    localparam int unsigned CtrlEnableBit = 0;
    localparam int unsigned CtrlBlinkBit  = 1;
    localparam int unsigned CtrlInvertBit = 2;

    localparam logic [2:0] CtrlReset = 3'b001;

endpackage

// File: rtl/pcihellocore_led_pwm.sv
// Free-running PWM counter with duty compare; full-scale duty means solid on.
module pcihellocore_led_pwm #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                pwm_on_o
);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = enable_i ? cnt_q + PWM_BITS'(1) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // All-ones duty bypasses the compare so there is no single-count dark gap.
    assign pwm_on_o = (&duty_i) || (cnt_q < duty_i);

endmodule

// File: rtl/pcihellocore_led_driver.sv
// LED pin driver: PWM brightness, per-bit blink and polarity on top of the PIO pattern.
module pcihellocore_led_driver
    import pcihellocore_led_driver_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned BLINK_BITS = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] pattern_in,
    output logic [WIDTH-1:0] led_out
);

    logic [2:0]            ctrl_q, ctrl_d;
    logic [PWM_BITS-1:0]   duty_q, duty_d;
    logic [BLINK_BITS-1:0] period_q, period_d;
    logic [WIDTH-1:0]      mask_q, mask_d;
    logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [WIDTH-1:0]      led_q, led_d;

    logic wr_en;
    logic period_wr;
    logic enable, blink_en, invert;
    logic pwm_on;
    logic unused_wdata;

    assign wr_en     = chipselect && !write_n;
    assign period_wr = wr_en && (address == AddrPeriod);
    assign enable    = ctrl_q[CtrlEnableBit];
    assign blink_en  = ctrl_q[CtrlBlinkBit];
    assign invert    = ctrl_q[CtrlInvertBit];

    assign unused_wdata = ^writedata[31:WIDTH];

    always_comb begin
        ctrl_d   = ctrl_q;
        duty_d   = duty_q;
        period_d = period_q;
        mask_d   = mask_q;
        if (wr_en) begin
            unique case (address)
                AddrCtrl:   ctrl_d   = writedata[2:0];
                AddrDuty:   duty_d   = writedata[PWM_BITS-1:0];
                AddrPeriod: period_d = writedata[BLINK_BITS-1:0];
                AddrMask:   mask_d   = writedata[WIDTH-1:0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            AddrCtrl:   readdata[2:0]            = ctrl_q;
            AddrDuty:   readdata[PWM_BITS-1:0]   = duty_q;
            AddrPeriod: readdata[BLINK_BITS-1:0] = period_q;
            AddrMask:   readdata[WIDTH-1:0]      = mask_q;
            default:    ;
        endcase
    end

    pcihellocore_led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable_i (enable),
        .duty_i   (duty_q),
        .pwm_on_o (pwm_on)
    );

    // A PERIOD write restarts the blink timer and takes priority over a rollover.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (period_wr || !blink_en || (period_q == '0)) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (blink_cnt_q == period_q - BLINK_BITS'(1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
        end
    end

    always_comb begin
        logic [WIDTH-1:0] raw;
        raw = pattern_in & ~(mask_q & {WIDTH{blink_en && !blink_phase_q}});
        raw = raw & {WIDTH{pwm_on && enable}};
        led_d = raw ^ {WIDTH{invert}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= CtrlReset;
            duty_q        <= '1;
            period_q      <= '0;
            mask_q        <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            led_q         <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            duty_q        <= duty_d;
            period_q      <= period_d;
            mask_q        <= mask_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_q         <= led_d;
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_pcihellocore_led_driver.sv
// Bench for the LED driver: behavioural model compared every cycle plus directed literal checks.
module tb_pcihellocore_led_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [15:0] pattern_in = 16'h0000;
    logic [15:0] led_out;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pcihellocore_led_driver #(
        .WIDTH      (16),
        .PWM_BITS   (8),
        .BLINK_BITS (24)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pattern_in (pattern_in),
        .led_out    (led_out)
    );

    // Model: PWM position is cycles-since-enable mod 256; blink phase is derived
    // from cycles-since-restart divided by the half-period.
    logic [2:0]  m_ctrl = 3'b001;
    logic [7:0]  m_duty = 8'hFF;
    logic [23:0] m_period = 24'd0;
    logic [15:0] m_mask = 16'h0000;
    logic [15:0] m_led = 16'h0000;
    int          m_pwm_t = 0;
    int          m_blink_t = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ctrl    = 3'b001;
            m_duty    = 8'hFF;
            m_period  = 24'd0;
            m_mask    = 16'h0000;
            m_led     = 16'h0000;
            m_pwm_t   = 0;
            m_blink_t = 0;
        end else begin
            bit          gate;
            bit          off;
            bit          wr;
            logic [15:0] raw;
            gate = m_ctrl[0] && ((m_duty == 8'hFF) || ((m_pwm_t % 256) < int'(m_duty)));
            off  = m_ctrl[1] && (m_period != 0) && (((m_blink_t / int'(m_period)) % 2) == 1);
            raw  = pattern_in & (off ? ~m_mask : 16'hFFFF);
            if (!gate) raw = 16'h0000;
            m_led = m_ctrl[2] ? ~raw : raw;
            wr = chipselect && !write_n;
            m_pwm_t = m_ctrl[0] ? m_pwm_t + 1 : 0;
            if (wr && address == 2'd2) m_blink_t = 0;
            else if (!m_ctrl[1] || m_period == 0) m_blink_t = 0;
            else m_blink_t = m_blink_t + 1;
            if (wr) begin
                case (address)
                    2'd0: m_ctrl = writedata[2:0];
                    2'd1: m_duty = writedata[7:0];
                    2'd2: m_period = writedata[23:0];
                    default: m_mask = writedata[15:0];
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && reset_n) check("led_vs_model", {16'h0, led_out}, {16'h0, m_led});
    end

    // Call at a negedge; returns at the negedge after the write edge.
    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic reg_read(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    logic [15:0] samp [0:39];
    int          cnt_on;
    int          cnt_dim;
    bit          found;

    initial begin
        // 1: reset and pass-through
        pattern_in = 16'hA5A5;
        repeat (3) @(negedge clk);
        check("led_in_reset", {16'h0, led_out}, 32'h0);
        pattern_in = 16'h0000;
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        pattern_in = 16'hA5A5;
        #1;
        check("led_before_edge", {16'h0, led_out}, 32'h0);
        @(negedge clk);
        check("led_passthru", {16'h0, led_out}, 32'h0000A5A5);
        reg_read("rd_ctrl_rst", 2'd0, 32'd1);
        reg_read("rd_duty_rst", 2'd1, 32'd255);
        reg_read("rd_period_rst", 2'd2, 32'd0);
        reg_read("rd_mask_rst", 2'd3, 32'd0);

        // 2: PWM duty
        pattern_in = 16'hFFFF;
        @(negedge clk);
        reg_write(2'd1, 32'hFFFF_FF40);
        reg_read("rd_duty_64", 2'd1, 32'd64);
        cnt_on = 0;
        repeat (256) begin
            @(negedge clk);
            if (led_out == 16'hFFFF) cnt_on++;
        end
        check("pwm_duty64_on_count", cnt_on, 64);
        reg_write(2'd1, 32'd0);
        cnt_on = 0;
        repeat (256) begin
            @(negedge clk);
            if (led_out != 16'h0000) cnt_on++;
        end
        check("pwm_duty0_on_count", cnt_on, 0);
        reg_write(2'd1, 32'd255);
        cnt_on = 0;
        repeat (256) begin
            @(negedge clk);
            if (led_out == 16'hFFFF) cnt_on++;
        end
        check("pwm_duty255_on_count", cnt_on, 256);

        // 3: blink with half-period 10
        reg_write(2'd3, 32'h0000_00FF);
        reg_write(2'd0, 32'd3);
        reg_write(2'd2, 32'd10);
        cnt_dim = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            samp[i] = led_out;
            if (led_out == 16'hFF00) cnt_dim++;
        end
        check("blink_dim_count", cnt_dim, 20);
        check("blink_s0", {16'h0, samp[0]}, 32'hFFFF);
        check("blink_s9", {16'h0, samp[9]}, 32'hFFFF);
        check("blink_s10", {16'h0, samp[10]}, 32'hFF00);
        check("blink_s19", {16'h0, samp[19]}, 32'hFF00);
        check("blink_s20", {16'h0, samp[20]}, 32'hFFFF);

        // 4: PERIOD write coincident with rollover
        reg_write(2'd2, 32'd10);
        repeat (9) @(negedge clk);
        reg_write(2'd2, 32'd4);
        samp[0] = led_out;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            samp[i] = led_out;
        end
        for (int i = 0; i < 5; i++) check("wr_beats_rollover_on", {16'h0, samp[i]}, 32'hFFFF);
        check("wr_beats_rollover_first_toggle", {16'h0, samp[5]}, 32'hFF00);

        // 5: polarity
        pattern_in = 16'h000F;
        reg_write(2'd0, 32'd5);
        @(negedge clk);
        check("invert_on", {16'h0, led_out}, 32'hFFF0);
        reg_write(2'd0, 32'd4);
        @(negedge clk);
        check("invert_disabled", {16'h0, led_out}, 32'hFFFF);

        // 6: async reset during dim phase
        pattern_in = 16'hFFFF;
        reg_write(2'd0, 32'd3);
        reg_write(2'd2, 32'd10);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (led_out == 16'hFF00) found = 1'b1;
        end
        check("dim_phase_reached", {31'h0, found}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("led_async_reset", {16'h0, led_out}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        reg_read("rd_ctrl_after", 2'd0, 32'd1);
        reg_read("rd_duty_after", 2'd1, 32'd255);
        reg_read("rd_period_after", 2'd2, 32'd0);
        reg_read("rd_mask_after", 2'd3, 32'd0);
        @(negedge clk);
        reg_write(2'd3, 32'h0000_00FF);
        reg_write(2'd0, 32'd3);
        @(negedge clk);
        check("blink_restart_phase1", {16'h0, led_out}, 32'hFFFF);
        reg_write(2'd2, 32'd10);
        repeat (30) @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pcihellocore_led_driver.md
Name: pcihellocore_led_driver

Overview:
- Downstream consumer of the green-LED PIO output port. Takes the 16-bit pattern and drives the physical LED pins.
- Adds global PWM brightness, per-bit blinking and output polarity control.
- Configured by the host through its own small Avalon-MM slave (s1) on the same clock domain.
- Sits between the PIO's out_port and the top-level LED pins.

Parameters:
WIDTH, 16, number of LED bits; pattern and output width
PWM_BITS, 8, width of the PWM counter and DUTY field
BLINK_BITS, 24, width of the blink half-period counter and PERIOD field

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
address  input  2  Avalon-MM register select
chipselect  input  1  Avalon-MM select
write_n  input  1  Avalon-MM write strobe, active-low
writedata  input  32  Avalon-MM write data
readdata  output  32  Avalon-MM read data, combinational, zero-padded
pattern_in  input  WIDTH  LED pattern from the PIO out_port
led_out  output  WIDTH  registered LED pin drive

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n). Every flop clears on reset_n low, independent of clk.
- Registers (write when chipselect && !write_n; takes effect the next cycle):
  - addr 0 CTRL[2:0]: bit0 enable, bit1 blink_en, bit2 invert. Reset 3'b001.
  - addr 1 DUTY[PWM_BITS-1:0]. Reset all-ones.
  - addr 2 PERIOD[BLINK_BITS-1:0]: blink half-period in clk cycles. Reset 0.
  - addr 3 MASK[WIDTH-1:0]: bits subject to blinking. Reset 0.
- Writes use the low writedata bits only; upper bits are ignored.
- Reads: readdata = zero-extended register selected by address, regardless of chipselect; 0 read wait states.
- PWM:
  - pwm_cnt is free-running, increments every clk, wraps 2^PWM_BITS-1 -> 0.
  - Held at 0 while enable=0.
  - pwm_on = (DUTY == all-ones) || (pwm_cnt < DUTY).
  - DUTY=0 gives always off; DUTY=all-ones gives always on, with no 1/256 gap.
- Blink:
  - blink_cnt counts 0..PERIOD-1; at PERIOD-1 it returns to 0 and toggles blink_phase.
  - PERIOD=0 or blink_en=0: blink_cnt held at 0, blink_phase held at 1.
  - Any write to PERIOD resets blink_cnt to 0 and blink_phase to 1 that same edge. The write wins over a coincident rollover.
  - Reset: blink_phase = 1.
- Output, registered, 1-cycle latency from pattern_in/state to led_out:
  - gate = pwm_on && enable
  - raw = pattern_in & ~(MASK & {WIDTH{blink_en && !blink_phase}}) & {WIDTH{gate}}
  - led_out <= raw ^ {WIDTH{invert}}
  - With enable=0, led_out = {WIDTH{invert}} (all LEDs off in either polarity).
- Reset value of led_out: 0.
  - After reset: enable=1, DUTY=max, MASK=0, so led_out follows pattern_in with 1-cycle delay.
- Simultaneous CTRL write and PWM/blink tick: the counters use the old CTRL value on that edge, the new value from the next edge.
- Reset mid-operation: all counters, registers and led_out return to reset values immediately (async). No partial blink phase survives.

Decomposition:
- No shared package needed. Define register offsets (CTRL=0, DUTY=1, PERIOD=2, MASK=3) and CTRL bit indices as localparams.
- If the team keeps a pcihellocore register-map include, place them there.
- One natural sub-module: pcihellocore_led_pwm (pwm_cnt plus the pwm_on compare), reusable for other LED banks. The blink timer stays inline.

Test Plan:
1. Reset, then pattern_in=16'hA5A5 -> led_out=16'h0000 during reset; led_out=16'hA5A5 exactly 1 cycle after pattern applied; readdata at addr0/1/2/3 = 1, 255, 0, 0.
2. Write DUTY=64, pattern_in=16'hFFFF -> over 256 cycles led_out=16'hFFFF for exactly 64 cycles and 0 for 192, repeating. DUTY=0 -> never on; DUTY=255 -> always on.
3. CTRL=3'b011, PERIOD=10, MASK=16'h00FF, pattern_in=16'hFFFF -> led_out alternates 16'hFFFF for 10 cycles and 16'hFF00 for 10 cycles.
4. Write PERIOD=4 on the same cycle blink_cnt hits PERIOD-1 -> no toggle; blink_phase=1, blink_cnt=0 next cycle; first toggle 4 cycles later.
5. CTRL=3'b101 (invert), pattern_in=16'h000F -> led_out=16'hFFF0. CTRL=3'b100 -> led_out=16'hFFFF.
6. Assert reset_n low mid-blink, off phase, between clk edges -> led_out=0 immediately. After release, registers read back reset values and blink restarts in phase 1.
